// File: rtl/regfile_2r1w_sb.sv
// 32x32 architectural register file: two registered read ports with write
// bypass, one writeback port and a pending-write scoreboard.

module register32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!reset)    data_q <= '0;
    else if (en_i) data_q <= d_i;
  end

  assign q_o = data_q;

endmodule

module regfile_2r1w_sb #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_pend_a,
  output logic             rd_pend_b,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic             rsv_ok,
  output logic             wr_err
);

  logic [NREGS-1:0] wr_dec;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
  logic             rd_pend_a_q, rd_pend_a_d, rd_pend_b_q, rd_pend_b_d;
  logic             wr_err_q, wr_err_d;

  // Bit 0 of the decode is never set, so R0 writes vanish here.
  always_comb begin
    wr_dec = '0;
    for (int n = 1; n < NREGS; n++)
      wr_dec[n] = wr_en && (wr_addr == AW'(n));
  end

  assign regs_q[0] = '0;

  for (genvar n = 1; n < NREGS; n++) begin : g_reg
    register32 #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .reset (reset),
      .en_i  (wr_dec[n]),
      .d_i   (wr_data),
      .q_o   (regs_q[n])
    );
  end

  // A writeback retiring the same register frees the slot for a new reservation.
  assign rsv_ok = rsv_en && (rsv_addr != '0) &&
                  (!pend_q[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));

  always_comb begin
    pend_d = pend_q;
    for (int n = 1; n < NREGS; n++) begin
      if (rsv_ok && (rsv_addr == AW'(n))) pend_d[n] = 1'b1;
      else if (wr_dec[n])                 pend_d[n] = 1'b0;
    end
    pend_d[0] = 1'b0;
  end

  // Read outputs reflect the state after this edge's write and reservation.
  always_comb begin
    rd_data_a_d = wr_dec[rd_addr_a] ? wr_data : regs_q[rd_addr_a];
    rd_data_b_d = wr_dec[rd_addr_b] ? wr_data : regs_q[rd_addr_b];
    rd_pend_a_d = pend_d[rd_addr_a];
    rd_pend_b_d = pend_d[rd_addr_b];
    wr_err_d    = wr_en && (wr_addr != '0) && !pend_q[wr_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_q      <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_pend_a_q <= 1'b0;
      rd_pend_b_q <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      rd_pend_a_q <= rd_pend_a_d;
      rd_pend_b_q <= rd_pend_b_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign rd_pend_a = rd_pend_a_q;
  assign rd_pend_b = rd_pend_b_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Randomized scoreboard bench for regfile_2r1w_sb against an array-based
// model of architectural register and reservation state.

module tb_regfile_2r1w_sb;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0, rsv_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_en = 1'b0, rsv_en = 1'b0;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_pend_a, rd_pend_b, rsv_ok, wr_err;

  regfile_2r1w_sb dut (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_pend_a(rd_pend_a), .rd_pend_b(rd_pend_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] da;
    logic        pa;
    logic [31:0] db;
    logic        pb;
    logic        err;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] mem  [32];
  bit          pend [32];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, check rsv_ok, advance the model, queue the
  // response due after the next edge.
  task automatic drive(input bit rst_n, input logic [4:0] ra, input logic [4:0] rb,
                       input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit re, input logic [4:0] sa);
    bit   ok, err;
    exp_t e;
    @(negedge clk);
    reset = rst_n; rd_addr_a = ra; rd_addr_b = rb;
    wr_en = we; wr_addr = wa; wr_data = wd; rsv_en = re; rsv_addr = sa;
    #1;
    ok = re && sa != 0 && (!pend[sa] || (we && wa == sa));
    chk("rsv_ok", {31'b0, rsv_ok}, {31'b0, ok});
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin mem[i] = '0; pend[i] = 0; end
      e = '0;
    end else begin
      err = we && wa != 0 && !pend[wa];
      if (we && wa != 0) begin mem[wa] = wd; pend[wa] = 0; end
      if (ok) pend[sa] = 1;
      e.da  = mem[ra];
      e.pa  = pend[ra];
      e.db  = mem[rb];
      e.pb  = pend[rb];
      e.err = err;
    end
    expq.push_back(e);
  endtask

  task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
    drive(1, ra, rb, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [4:0] raddr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("rd_data_a", rd_data_a, e.da);
        chk("rd_pend_a", {31'b0, rd_pend_a}, {31'b0, e.pa});
        chk("rd_data_b", rd_data_b, e.db);
        chk("rd_pend_b", {31'b0, rd_pend_b}, {31'b0, e.pb});
        chk("wr_err", {31'b0, wr_err}, {31'b0, e.err});
      end
    end
  end

  initial begin : stim
    for (int i = 0; i < 32; i++) begin mem[i] = '0; pend[i] = 0; end
    // reset then reads
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    idle(5, 31);
    // reserve, write with same-cycle read
    drive(1, 0, 0, 0, 0, 0, 1, 7);
    idle(7, 0);
    drive(1, 7, 7, 1, 7, 32'hDEADBEEF, 0, 0);
    idle(7, 7);
    // double reservation, then write + re-reserve
    drive(1, 0, 0, 0, 0, 0, 1, 3);
    drive(1, 3, 0, 0, 0, 0, 1, 3);
    drive(1, 3, 3, 1, 3, 32'h11, 1, 3);
    idle(3, 3);
    // R0 handling
    drive(1, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0);
    idle(0, 0);
    // unreserved write
    drive(1, 9, 0, 1, 9, 32'h1234, 0, 0);
    idle(9, 9);
    idle(9, 0);
    // reset mid-operation
    drive(1, 0, 0, 0, 0, 0, 1, 4);
    drive(1, 0, 0, 0, 0, 0, 1, 6);
    drive(1, 6, 4, 1, 6, 32'h55, 0, 0);
    drive(0, 4, 6, 1, 4, 32'h77, 1, 4);
    idle(4, 6);
    idle(6, 4);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 99) != 0, raddr(), raddr(),
            $urandom_range(0, 1) == 1, raddr(), $urandom(),
            $urandom_range(0, 1) == 1, raddr());
    end
    idle(0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w_sb.md
Name: regfile_2r1w_sb

Overview:
- 32-entry x 32-bit architectural register file for the 32-bit RISC core; instantiates one register32 per entry, R1..R31.
- Adds a write-address decoder, two registered read ports with write bypass, and a pending-write scoreboard.
- Decode reserves a destination at issue; writeback stores the result and clears the reservation.
- Read ports return data together with a pending flag, which the hazard unit uses to stall.

Parameters:
- WIDTH, 32, data width of each register.
- NREGS, 32, number of registers; R0 is hardwired zero.
- AW, 5, address width; must equal log2(NREGS).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- rd_addr_a  input  AW  read port A address, sampled every cycle.
- rd_addr_b  input  AW  read port B address, sampled every cycle.
- rd_data_a  output  WIDTH  port A data, registered.
- rd_data_b  output  WIDTH  port B data, registered.
- rd_pend_a  output  1  port A register has an outstanding reservation, registered.
- rd_pend_b  output  1  port B register has an outstanding reservation, registered.
- wr_en  input  1  writeback strobe.
- wr_addr  input  AW  writeback destination.
- wr_data  input  WIDTH  writeback value.
- rsv_en  input  1  issue-time reservation request.
- rsv_addr  input  AW  register to reserve.
- rsv_ok  output  1  combinational: reservation is accepted this cycle.
- wr_err  output  1  registered one-cycle pulse: a write hit a register that was not pending.

Behaviour:
- One clock domain. Everything updates on the rising edge of clk.
- Reset (reset==0 at an edge):
  - All registers, all pend bits, rd_data_a/b, rd_pend_a/b and wr_err go to 0.
  - Reset overrides wr_en and rsv_en in the same cycle.
  - Asserting reset mid-sequence discards every outstanding reservation.
- Per-register enable:
  - Enable for Rn = wr_en & (wr_addr==n) & (n!=0).
  - Exactly one register is enabled per cycle, or none.
  - Writes to R0 are dropped. No error is raised for them.
- Read latency is 1 cycle. rd_data_x at edge k+1 holds the value of rd_addr_x sampled at edge k, after edge k's write has taken effect:
  - if wr_en and wr_addr==rd_addr_x and rd_addr_x!=0, the output is wr_data (bypass);
  - otherwise the output is the stored value;
  - rd_addr_x==0 always gives 0.
- Scoreboard: one pend bit per register. pend[0] is constant 0.
- rsv_ok = rsv_en & (rsv_addr!=0) & (~pend[rsv_addr] | (wr_en & wr_addr==rsv_addr)).
  - A same-cycle writeback frees the slot, so the new reservation is accepted.
  - rsv_addr==0 gives rsv_ok=0 and no state change.
- Pend bit update at each edge, in priority order:
  - set if the reservation to that address is accepted;
  - else cleared if wr_en hits that address;
  - else held.
  - Same-cycle writeback and new reservation to one register: data is written and pend ends at 1.
- rd_pend_x is the post-edge pend value of the sampled address, consistent with rd_data_x. rd_pend_x=0 for R0.
- wr_err:
  - Set for one cycle when wr_en & wr_addr!=0 & pend[wr_addr]==0 before the edge.
  - The write still completes.
- A rejected reservation (already pending, no same-cycle writeback) leaves all state unchanged. Issue must retry.
- Both read ports may address the same register, and may also match wr_addr. Each port bypasses independently.
- Implementation size is 120-400 lines: decoder, 31 register32 instances, read muxes, bypass, scoreboard.

Test Plan:
1. Reset then reads: hold reset=0 for 2 cycles. Release, set rd_addr_a=5, rd_addr_b=31 -> next cycle rd_data_a=0, rd_data_b=0, rd_pend_a/b=0, wr_err=0.
2. Reserve, write, read: rsv_en, rsv_addr=7 -> rsv_ok=1. Next cycle rd_addr_a=7 -> rd_pend_a=1. Then wr_en, wr_addr=7, wr_data=0xDEADBEEF with rd_addr_a=7 the same cycle -> next cycle rd_data_a=0xDEADBEEF, rd_pend_a=0, wr_err=0.
3. Double reservation: reserve R3 (ok=1). Next cycle rsv_addr=3 again -> rsv_ok=0. Then wr_en R3=0x11 together with rsv_en R3 -> rsv_ok=1; afterwards rd R3 gives data 0x11, pend=1.
4. R0 handling: wr_en, wr_addr=0, data=0xFFFFFFFF; rsv_en, rsv_addr=0 -> rsv_ok=0, wr_err=0. Reading R0 on both ports -> 0, pend 0.
5. Unreserved write: wr_en R9=0x1234 with R9 not pending -> wr_err=1 for exactly one cycle. Next read of R9 gives 0x1234.
6. Reset mid-operation: reserve R4 and R6, write R6=0x55. Assert reset=0 in the same cycle as wr_en R4 -> after release, R4, R6 read 0, pend 0, wr_err=0.
